dcache_way_array: RTL

Parametrised N-way L1 data-cache storage array: per-way byte-enabled data RAM plus per-set tag RAM holding {valid, dirty, tag}.
- Registered tag compare produces a one-hot hit vector one cycle after a read.
- Built-in sweep sequencer clears all tag entries after reset and on an explicit invalidate request.
- Sits between the LSU pipeline (read/compare) and the refill/writeback controller (writes, invalidate).

---
 rtl/dcache_way_array.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dcache_way_array.sv
// dcache_way_array: N-way L1 D$ data/tag storage with registered tag compare.
// Optional same-cycle write-to-read forwarding: define DCACHE_WAY_BYPASS_EN.
module dcache_way_array #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4,
  parameter int TAG_WIDTH  = 20,
  localparam int IDX_W     = $clog2(SETS),
  localparam int OFS_W     = $clog2(LINE_WORDS),
  localparam int AW        = IDX_W + OFS_W,
  localparam int EW        = TAG_WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready_o,
  input  logic                 inv_req_i,
  input  logic                 r_req_i,
  input  logic [AW-1:0]        r_addr_i,
  input  logic [TAG_WIDTH-1:0] r_tag_i,
  output logic                 r_valid_o,
  output logic [WAYS*32-1:0]   r_data_o,
  output logic [WAYS*EW-1:0]   r_tag_o,
  output logic [WAYS-1:0]      r_hit_o,
  input  logic [WAYS-1:0]      w_way_i,
  input  logic [3:0]           data_we_i,
  input  logic [AW-1:0]        w_addr_i,
  input  logic [31:0]          data_i,
  input  logic                 tag_we_i,
  input  logic [EW-1:0]        tag_i
);

  localparam int DEPTH = SETS * LINE_WORDS;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_INV,
    ST_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               sweep;
  logic               rd_en;
  logic [TAG_WIDTH-1:0] cmp_tag_q;
  logic [IDX_W-1:0]   r_idx, w_idx;

  assign ready_o = (state_q == ST_IDLE);
  assign sweep   = ~ready_o;
  assign rd_en   = r_req_i & ready_o;
  assign r_idx   = r_addr_i[AW-1:OFS_W];
  assign w_idx   = w_addr_i[AW-1:OFS_W];

  // State and sweep counter; reset restarts the clear sweep at set 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep runs SETS cycles; invalidate is only taken while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT, ST_INV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1))
          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (inv_req_i) begin
          state_d = ST_INV;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Read-valid flag and the compare tag captured with the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_o <= 1'b0;
      cmp_tag_q <= '0;
    end else begin
      r_valid_o <= rd_en;
      if (rd_en)
        cmp_tag_q <= r_tag_i;
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic [EW-1:0] tag_mem [SETS];
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   wr_word;
    logic [31:0]   rd_data;
    logic [EW-1:0] rd_tag;
    logic [31:0]   data_q;
    logic [EW-1:0] tag_q;

    // Sweep clears the entry at cnt; otherwise refill writes are taken.
    always_ff @(posedge clk) begin
      if (sweep)
        tag_mem[cnt_q] <= '0;
      else if (w_way_i[g] && tag_we_i)
        tag_mem[w_idx] <= tag_i;
    end

    // Byte merge of the write data over the current word.
    always_comb begin
      wr_word = data_mem[w_addr_i];
      for (int b = 0; b < 4; b++)
        if (data_we_i[b])
          wr_word[8*b +: 8] = data_i[8*b +: 8];
    end

    // Data write, blocked while the sweep owns the array.
    always_ff @(posedge clk) begin
      if (ready_o && w_way_i[g] && |data_we_i)
        data_mem[w_addr_i] <= wr_word;
    end

    // Array read port, with optional forwarding of a same-cycle write.
    always_comb begin
      rd_data = data_mem[r_addr_i];
      rd_tag  = tag_mem[r_idx];
`ifdef DCACHE_WAY_BYPASS_EN
      if (w_way_i[g] && w_addr_i == r_addr_i)
        for (int b = 0; b < 4; b++)
          if (data_we_i[b])
            rd_data[8*b +: 8] = data_i[8*b +: 8];
      if (w_way_i[g] && tag_we_i && w_idx == r_idx)
        rd_tag = tag_i;
`endif
    end

    // Output registers hold their value between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        tag_q  <= '0;
      end else if (rd_en) begin
        data_q <= rd_data;
        tag_q  <= rd_tag;
      end
    end

    assign r_data_o[32*g +: 32] = data_q;
    assign r_tag_o[EW*g +: EW]  = tag_q;
    assign r_hit_o[g] = r_valid_o & tag_q[EW-1] &
                        (tag_q[TAG_WIDTH-1:0] == cmp_tag_q);
  end

endmodule
